// File: rtl/instr_encoder.sv
// Packs symbolic instructions into 32-bit MIPS words and streams them into
// instruction memory one word per cycle, starting at BASE_ADDR.
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        mnem,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              full,
   output logic              illegal
);

   localparam logic [3:0] M_NOOP    = 4'd0;
   localparam logic [3:0] M_LW      = 4'd1;
   localparam logic [3:0] M_SW      = 4'd2;
   localparam logic [3:0] M_J       = 4'd3;
   localparam logic [3:0] M_JR      = 4'd4;
   localparam logic [3:0] M_JAL     = 4'd5;
   localparam logic [3:0] M_BNE     = 4'd6;
   localparam logic [3:0] M_XORI    = 4'd7;
   localparam logic [3:0] M_ADD     = 4'd8;
   localparam logic [3:0] M_SUB     = 4'd9;
   localparam logic [3:0] M_SLT     = 4'd10;
   localparam logic [3:0] M_SYSCALL = 4'd11;

   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [ADDR_W:0]   ptr_q, ptr_d;
   logic              done_q, done_d;
   logic              full_q, full_d;
   logic              illegal_q, illegal_d;

   logic [31:0]       word;
   logic              legal;
   logic              accept;

   // Unused fields of each format are simply left out of the concatenation.
   always_comb begin
      word  = 32'h0;
      legal = 1'b1;
      case (mnem)
         M_NOOP:    word = 32'h0;
         M_LW:      word = {6'b100011, rs, rt, imm};
         M_SW:      word = {6'b101011, rs, rt, imm};
         M_J:       word = {6'b000010, target};
         M_JR:      word = {6'b000000, rs, 15'b0, 6'b001000};
         M_JAL:     word = {6'b000011, target};
         M_BNE:     word = {6'b000101, rs, rt, imm};
         M_XORI:    word = {6'b001110, rs, rt, imm};
         M_ADD:     word = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
         M_SUB:     word = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
         M_SLT:     word = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
         M_SYSCALL: word = 32'h0000000C;
         default:   legal = 1'b0;
      endcase
   end

   assign in_ready = !reset && !clear && !done_q && !full_q;
   assign accept   = in_valid && in_ready;

   // clear only rewinds bookkeeping; a write registered last cycle still
   // drives memory during the clear cycle.
   always_comb begin
      ptr_d       = ptr_q;
      done_d      = done_q;
      full_d      = full_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      illegal_d   = 1'b0;
      if (clear) begin
         ptr_d  = '0;
         done_d = 1'b0;
         full_d = 1'b0;
      end else if (accept) begin
         if (legal) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_W'(BASE_ADDR) + ptr_q[ADDR_W-1:0];
            mem_wdata_d = word;
            ptr_d       = ptr_q + 1'b1;
            if (ptr_d == (ADDR_W+1)'(DEPTH)) full_d = 1'b1;
            if (mnem == M_SYSCALL)           done_d = 1'b1;
         end else begin
            illegal_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= ADDR_W'(BASE_ADDR);
         mem_wdata_q <= 32'h0;
         ptr_q       <= '0;
         done_q      <= 1'b0;
         full_q      <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ptr_q       <= ptr_d;
         done_q      <= done_d;
         full_q      <= full_d;
         illegal_q   <= illegal_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign count     = ptr_q;
   assign done      = done_q;
   assign full      = full_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus hand-written
// sequences for illegal, SYSCALL/done, clear, reset and the full boundary.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset, clear, in_valid_a, in_valid_b;
   logic [3:0]  mnem;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [25:0] target;

   logic        in_ready_a, mem_we_a, done_a, full_a, illegal_a;
   logic [7:0]  mem_addr_a;
   logic [31:0] mem_wdata_a;
   logic [8:0]  count_a;

   logic        in_ready_b, mem_we_b, done_b, full_b, illegal_b;
   logic [7:0]  mem_addr_b;
   logic [31:0] mem_wdata_b;
   logic [8:0]  count_b;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd),
      .imm(imm), .target(target), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .count(count_a), .done(done_a),
      .full(full_a), .illegal(illegal_a)
   );

   instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut4 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd),
      .imm(imm), .target(target), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .count(count_b), .done(done_b),
      .full(full_b), .illegal(illegal_b)
   );

   typedef struct {
      logic [3:0]  mnem;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] target;
      logic [31:0] word;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
      mnem = m; rs = s; rt = t; rd = d; imm = i; target = tg;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Unused fields carry nonzero junk to prove they are masked.
      vecs[0]  = '{4'd8,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h00221820}; // ADD
      vecs[1]  = '{4'd1,  5'd29, 5'd8,  5'd31, 16'h0004, 26'h3FFFFFF, 32'h8FA80004}; // LW
      vecs[2]  = '{4'd3,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 32'h08000010}; // J
      vecs[3]  = '{4'd7,  5'd5,  5'd5,  5'd9,  16'hFFFF, 26'h0001234, 32'h38A5FFFF}; // XORI
      vecs[4]  = '{4'd2,  5'd29, 5'd31, 5'd7,  16'h0010, 26'h3FFFFFF, 32'hAFBF0010}; // SW
      vecs[5]  = '{4'd6,  5'd4,  5'd5,  5'd1,  16'hFFFE, 26'h3FFFFFF, 32'h1485FFFE}; // BNE
      vecs[6]  = '{4'd9,  5'd8,  5'd9,  5'd10, 16'hABCD, 26'h3FFFFFF, 32'h01095022}; // SUB
      vecs[7]  = '{4'd10, 5'd2,  5'd3,  5'd1,  16'hFFFF, 26'h3FFFFFF, 32'h0043082A}; // SLT
      vecs[8]  = '{4'd4,  5'd31, 5'd7,  5'd7,  16'hFFFF, 26'h3FFFFFF, 32'h03E00008}; // JR
      vecs[9]  = '{4'd5,  5'd1,  5'd1,  5'd1,  16'hFFFF, 26'h3FFFFFF, 32'h0FFFFFFF}; // JAL
      vecs[10] = '{4'd0,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h00000000}; // NOOP

      reset = 1'b1; clear = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
      drive(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      tick(); tick();
      chk("rst_mem_we",    32'(mem_we_a),    32'h0);
      chk("rst_mem_addr",  32'(mem_addr_a),  32'h0);
      chk("rst_mem_wdata", mem_wdata_a,      32'h0);
      chk("rst_count",     32'(count_a),     32'h0);
      chk("rst_done",      32'(done_a),      32'h0);
      chk("rst_full",      32'(full_a),      32'h0);
      chk("rst_illegal",   32'(illegal_a),   32'h0);
      chk("rst_in_ready",  32'(in_ready_a),  32'h0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready_a), 32'h1);

      // Table: back-to-back accepts, one write per cycle at consecutive addresses.
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].target);
         in_valid_a = 1'b1;
         tick();
         $display("vec %0d mnem=%0d we=%0d addr=%0d wdata=%08h count=%0d",
                  i, vecs[i].mnem, mem_we_a, mem_addr_a, mem_wdata_a, count_a);
         chk("vec_mem_we",    32'(mem_we_a),   32'h1);
         chk("vec_mem_addr",  32'(mem_addr_a), 32'(i));
         chk("vec_mem_wdata", mem_wdata_a,     vecs[i].word);
         chk("vec_count",     32'(count_a),    32'(i + 1));
      end
      in_valid_a = 1'b0;
      tick();
      chk("idle_mem_we", 32'(mem_we_a), 32'h0);
      chk("idle_count",  32'(count_a),  32'd11);

      // Illegal mnemonic then SYSCALL.
      reset = 1'b1; tick(); reset = 1'b0;
      drive(4'd13, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h1);
      in_valid_a = 1'b1;
      tick();
      $display("seq illegal: illegal=%0d we=%0d count=%0d", illegal_a, mem_we_a, count_a);
      chk("ill_pulse",  32'(illegal_a), 32'h1);
      chk("ill_mem_we", 32'(mem_we_a),  32'h0);
      chk("ill_count",  32'(count_a),   32'h0);
      drive(4'd11, 5'd7, 5'd3, 5'd2, 16'hFFFF, 26'h3FFFFFF);
      tick();
      $display("seq syscall: we=%0d addr=%0d wdata=%08h done=%0d", mem_we_a, mem_addr_a, mem_wdata_a, done_a);
      chk("sys_illegal_off", 32'(illegal_a),  32'h0);
      chk("sys_mem_we",      32'(mem_we_a),   32'h1);
      chk("sys_mem_addr",    32'(mem_addr_a), 32'h0);
      chk("sys_mem_wdata",   mem_wdata_a,     32'h0000000C);
      chk("sys_done",        32'(done_a),     32'h1);
      chk("sys_count",       32'(count_a),    32'h1);
      chk("sys_in_ready",    32'(in_ready_a), 32'h0);
      tick();
      chk("sys_hold_mem_we",   32'(mem_we_a),   32'h0);
      chk("sys_hold_count",    32'(count_a),    32'h1);
      chk("sys_hold_in_ready", 32'(in_ready_a), 32'h0);
      chk("sys_hold_illegal",  32'(illegal_a),  32'h0);

      // clear after done.
      clear = 1'b1;
      #1;
      chk("clr_in_ready_during", 32'(in_ready_a), 32'h0);
      tick();
      clear = 1'b0;
      #1;
      $display("seq clear: count=%0d done=%0d in_ready=%0d", count_a, done_a, in_ready_a);
      chk("clr_count",    32'(count_a),    32'h0);
      chk("clr_done",     32'(done_a),     32'h0);
      chk("clr_in_ready", 32'(in_ready_a), 32'h1);
      drive(4'd0, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'h3FFFFFF);
      tick();
      chk("noop_mem_we",    32'(mem_we_a),   32'h1);
      chk("noop_mem_addr",  32'(mem_addr_a), 32'h0);
      chk("noop_mem_wdata", mem_wdata_a,     32'h0);
      chk("noop_count",     32'(count_a),    32'h1);

      // clear with a write pending: the write still shows, no accept in clear cycle.
      drive(4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      tick();
      chk("pend_mem_we",   32'(mem_we_a),   32'h1);
      chk("pend_mem_addr", 32'(mem_addr_a), 32'h1);
      chk("pend_wdata",    mem_wdata_a,     32'h00221820);
      clear = 1'b1;
      #1;
      chk("pend_clr_in_ready", 32'(in_ready_a), 32'h0);
      tick();
      clear = 1'b0; in_valid_a = 1'b0;
      $display("seq clear_pending: we=%0d count=%0d", mem_we_a, count_a);
      chk("pend_after_mem_we", 32'(mem_we_a), 32'h0);
      chk("pend_after_count",  32'(count_a),  32'h0);

      // reset the cycle after an accept.
      in_valid_a = 1'b1;
      drive(4'd9, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0);
      tick();
      drive(4'd10, 5'd2, 5'd3, 5'd1, 16'h0, 26'h0);
      tick();
      chk("pre_rst_mem_addr", 32'(mem_addr_a), 32'h1);
      chk("pre_rst_wdata",    mem_wdata_a,     32'h0043082A);
      reset = 1'b1; in_valid_a = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      $display("seq mid_reset: we=%0d addr=%0d wdata=%08h count=%0d", mem_we_a, mem_addr_a, mem_wdata_a, count_a);
      chk("mrst_mem_we",    32'(mem_we_a),   32'h0);
      chk("mrst_mem_addr",  32'(mem_addr_a), 32'h0);
      chk("mrst_mem_wdata", mem_wdata_a,     32'h0);
      chk("mrst_count",     32'(count_a),    32'h0);
      chk("mrst_done",      32'(done_a),     32'h0);
      chk("mrst_full",      32'(full_a),     32'h0);
      chk("mrst_illegal",   32'(illegal_a),  32'h0);
      chk("mrst_in_ready",  32'(in_ready_a), 32'h1);

      // DEPTH=4 instance: five ADDs offered, only four accepted.
      drive(4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      in_valid_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         $display("depth4 offer %0d: we=%0d addr=%0d count=%0d full=%0d", i, mem_we_b, mem_addr_b, count_b, full_b);
         if (i < 4) begin
            chk("d4_mem_we",   32'(mem_we_b),   32'h1);
            chk("d4_mem_addr", 32'(mem_addr_b), 32'(i));
            chk("d4_count",    32'(count_b),    32'(i + 1));
            chk("d4_full",     32'(full_b),     32'(i == 3));
         end else begin
            chk("d4_fifth_mem_we", 32'(mem_we_b),   32'h0);
            chk("d4_fifth_count",  32'(count_b),    32'h4);
            chk("d4_in_ready",     32'(in_ready_b), 32'h0);
            chk("d4_full_sticky",  32'(full_b),     32'h1);
         end
      end
      in_valid_b = 1'b0;

      // SYSCALL as the DEPTH-th word sets both done and full.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("d4_clr_full",  32'(full_b),  32'h0);
      chk("d4_clr_count", 32'(count_b), 32'h0);
      in_valid_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) drive(4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
         else        drive(4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
         tick();
      end
      in_valid_b = 1'b0;
      $display("depth4 syscall: addr=%0d wdata=%08h done=%0d full=%0d", mem_addr_b, mem_wdata_b, done_b, full_b);
      chk("d4_sys_mem_addr", 32'(mem_addr_b), 32'h3);
      chk("d4_sys_wdata",    mem_wdata_b,     32'h0000000C);
      chk("d4_sys_done",     32'(done_b),     32'h1);
      chk("d4_sys_full",     32'(full_b),     32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Writer side of the instruction-word interface whose fields (opcode, funct) the control decoder consumes.
- Accepts symbolic instructions (mnemonic code plus register, immediate and target fields) over a valid/ready handshake.
- Packs each into a 32-bit MIPS word and writes it sequentially into instruction memory for the fetch path.
- Used by testbenches and the program loader to build programs without hand-assembled hex.

Parameters:
ADDR_W, 8, instruction memory word-address width
DEPTH, 256, max words written before full; must be <= 2^ADDR_W
BASE_ADDR, 0, word address of first write

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  one-cycle pulse: rewind pointer, clear done/full
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept this cycle
mnem  input  4  0 NOOP, 1 LW, 2 SW, 3 J, 4 JR, 5 JAL, 6 BNE, 7 XORI, 8 ADD, 9 SUB, 10 SLT, 11 SYSCALL; 12-15 illegal
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register
imm  input  16  immediate / branch offset
target  input  26  jump target field
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  write word address
mem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  legal words written since reset/clear
done  output  1  sticky: SYSCALL written
full  output  1  sticky: DEPTH words written
illegal  output  1  one-cycle pulse: illegal mnemonic accepted

Behaviour:
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, done=0, full=0, illegal=0. Internal pointer=0.
- in_ready = !reset && !clear && !done && !full (combinational).
- Accept happens when in_valid && in_ready.
- On accept, the word is encoded and registered. The next cycle drives mem_we=1, mem_addr=BASE_ADDR+ptr(at accept), mem_wdata=word. mem_we is otherwise 0.
- Latency is 1 cycle. Throughput is one word per cycle.
- ptr and count increment at accept for legal mnemonics.
- Encoding:
  - R-type (ADD/SUB/SLT): {6'b000000, rs, rt, rd, 5'b0, funct}; funct ADD=100000, SUB=100010, SLT=101010.
  - JR: {6'b0, rs, 15'b0, 6'b001000}.
  - SYSCALL: 32'h0000000C.
  - NOOP: 32'h00000000.
  - I-type: {opcode, rs, rt, imm}; opcode LW=100011, SW=101011, BNE=000101, XORI=001110.
  - J/JAL: {opcode, target}; opcode J=000010, JAL=000011.
  - Fields not used by a format are ignored, and their bits are zero.
- Illegal mnemonic (12-15): the handshake completes, with no write and no ptr/count change. illegal=1 the following cycle.
- Accepting SYSCALL writes it normally. done=1 on the same cycle as its mem_we, so in_ready drops from then on. The cycle right after acceptance cannot accept a further word because done is computed from the accept: done is set at the accept edge.
- full is set at the edge where ptr reaches DEPTH. The last word is still written on the following cycle.
- If SYSCALL is the DEPTH-th word, both done and full are set.
- clear:
  - ptr=0, count=0, done=0, full=0.
  - Any pending write registered the previous cycle still completes this cycle at its original address.
  - No accept occurs in the clear cycle.
- reset mid-operation: the pending write is dropped (mem_we=0 next cycle) and all state returns to reset values.
- reset has priority over clear, and clear has priority over accept.
- mem_addr wraps modulo 2^ADDR_W only if BASE_ADDR+DEPTH exceeds the range. Configuring that is a usage error and has no special handling.

Test Plan:
- Reset, then ADD rd=3 rs=1 rt=2 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=32'h00221820, count=1.
- Back-to-back LW rt=8 rs=29 imm=4, J target=26'h10, XORI rt=5 rs=5 imm=16'hFFFF -> consecutive writes 32'h8FA80004 @0, 32'h08000010 @1, 32'h38A5FFFF @2, with no gaps.
- Send mnem=13 then SYSCALL (rs=7 also driven) -> illegal pulses once with no write; next write is 32'h0000000C @0; done=1; in_ready=0 while in_valid stays high.
- DEPTH=4 override, 5 ADDs offered -> 4 writes @0-3, full=1, in_ready=0, 5th word never accepted, count=4.
- clear asserted after done -> count=0, done=0, in_ready=1; next NOOP writes 32'h0 @0.
- reset asserted on the cycle after an accept -> no mem_we; all outputs at reset values next cycle.
